// File: rtl/fc_argmax_classifier_pkg.sv
// -----------------------------------------------------------------------------
// fc_argmax_classifier_pkg
//   Shared definitions for the LeNet5 argmax classifier stage: default sizing,
//   FSM state encoding and the class-index width derivation.
// -----------------------------------------------------------------------------
package fc_argmax_classifier_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_NUM_CLASSES = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of a class index; a single class still needs a 1-bit index.
    function automatic int class_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_argmax_classifier_class_select_mux.sv
// -----------------------------------------------------------------------------
// class_select_mux
//   Combinational NUM_CLASSES:1 word multiplexer over the packed capture bank.
//
// Ports:
//   bank  in  NUM_CLASSES*DATA_WIDTH  packed words, class k at [k*DATA_WIDTH +: DATA_WIDTH]
//   sel   in  CLASS_BITS              class index to read
//   word  out DATA_WIDTH              selected word (zero for an out-of-range index)
// -----------------------------------------------------------------------------
module class_select_mux #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CLASSES = 10,
    parameter int CLASS_BITS  = 4
) (
    input  logic [NUM_CLASSES*DATA_WIDTH-1:0] bank,
    input  logic [CLASS_BITS-1:0]             sel,
    output logic [DATA_WIDTH-1:0]             word
);

    always_comb begin
        // NOTE: assigning a default before any conditional assignment keeps
        // every path driven, so no latch is inferred.
        word = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (sel == CLASS_BITS'(k)) begin
                word = bank[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/fc_argmax_classifier.sv
// -----------------------------------------------------------------------------
// fc_argmax_classifier
//   Final LeNet5 stage. Captures the NUM_CLASSES parallel FC2 outputs on a
//   start pulse, scans them one per cycle with a signed compare, and reports
//   the index and value of the largest (lowest index wins ties).
//
// Ports:
//   clk                  in   system clock, rising edge
//   reset                in   asynchronous, active-high reset
//   start_from_previous  in   one-cycle capture pulse from FC2 (accepted in IDLE only)
//   fc_data_in           in   packed FC2 outputs, class k at [k*DATA_WIDTH +: DATA_WIDTH]
//   end_to_previous      out  high while IDLE (ready for a new vector)
//   busy                 out  high in SCAN or DONE
//   class_out            out  predicted class, held until the next result
//   max_value_out        out  winning value, held until the next result
//   class_valid          out  one-cycle pulse while results are fresh (DONE)
// -----------------------------------------------------------------------------
module fc_argmax_classifier
    import fc_argmax_classifier_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int NUM_CLASSES = DEFAULT_NUM_CLASSES,
    parameter int CLASS_BITS  = class_bits(NUM_CLASSES)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start_from_previous,
    input  logic [NUM_CLASSES*DATA_WIDTH-1:0] fc_data_in,
    output logic                              end_to_previous,
    output logic                              busy,
    output logic [CLASS_BITS-1:0]             class_out,
    output logic [DATA_WIDTH-1:0]             max_value_out,
    output logic                              class_valid
);

    localparam logic [CLASS_BITS-1:0] LAST_IDX       = CLASS_BITS'(NUM_CLASSES - 1);
    // Class 0 seeds the running best, so the scan starts at class 1.
    localparam logic [CLASS_BITS-1:0] FIRST_SCAN_IDX =
        (NUM_CLASSES > 1) ? CLASS_BITS'(1) : '0;

    state_e                            state_q, state_d;
    logic [NUM_CLASSES*DATA_WIDTH-1:0] bank_q;
    logic                              bank_load;
    logic [CLASS_BITS-1:0]             idx_q, idx_d;
    logic signed [DATA_WIDTH-1:0]      best_val_q, best_val_d;
    logic [CLASS_BITS-1:0]             best_idx_q, best_idx_d;
    logic signed [DATA_WIDTH-1:0]      cand;
    logic                              result_load;

    class_select_mux #(
        .DATA_WIDTH  (DATA_WIDTH),
        .NUM_CLASSES (NUM_CLASSES),
        .CLASS_BITS  (CLASS_BITS)
    ) u_class_select_mux (
        .bank (bank_q),
        .sel  (idx_q),
        .word (cand)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: registers use non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            state_q <= state_d;
        end
    end

    // ------------------------------------------ next state and scan datapath
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        bank_load  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_from_previous) begin
                    bank_load  = 1'b1;
                    best_val_d = fc_data_in[DATA_WIDTH-1:0];
                    best_idx_d = '0;
                    idx_d      = FIRST_SCAN_IDX;
                    state_d    = (NUM_CLASSES == 1) ? ST_DONE : ST_SCAN;
                end
            end
            ST_SCAN: begin
                // Strictly greater: an equal value never displaces the
                // earlier (lower-index) winner.
                if (cand > best_val_q) begin
                    best_val_d = cand;
                    best_idx_d = idx_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + CLASS_BITS'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Results are published on the edge that enters DONE, using the
    // post-compare values so the final class is included.
    assign result_load = (state_d == ST_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the capture bank is wide but is reset on purpose so a
            // vector aborted by reset leaves no stale data behind.
            bank_q        <= '0;
            idx_q         <= '0;
            best_val_q    <= '0;
            best_idx_q    <= '0;
            class_out     <= '0;
            max_value_out <= '0;
        end else begin
            if (bank_load) begin
                bank_q <= fc_data_in;
            end
            idx_q      <= idx_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            if (result_load) begin
                class_out     <= best_idx_d;
                max_value_out <= best_val_d;
            end
        end
    end

    // --------------------------------------------------- handshake outputs
    // Decoded straight from the state register, so these are glitch-free.
    assign end_to_previous = (state_q == ST_IDLE);
    assign busy            = (state_q == ST_SCAN) || (state_q == ST_DONE);
    assign class_valid     = (state_q == ST_DONE);

endmodule

// File: tb/tb_fc_argmax_classifier.sv
// -----------------------------------------------------------------------------
// tb_fc_argmax_classifier
//   Directed vectors with hand-computed argmax results for fc_argmax_classifier
//   at its default sizing (10 classes x 32 bits).
// -----------------------------------------------------------------------------
module tb_fc_argmax_classifier;

    localparam int DW = 32;
    localparam int NC = 10;
    localparam int CB = 4;
    localparam int LATENCY = NC - 1;

    logic               clk;
    logic               reset;
    logic               start_from_previous;
    logic [NC*DW-1:0]   fc_data_in;
    logic               end_to_previous;
    logic               busy;
    logic [CB-1:0]      class_out;
    logic [DW-1:0]      max_value_out;
    logic               class_valid;

    int total;
    int bad;
    int vals[NC];

    fc_argmax_classifier dut (
        .clk                 (clk),
        .reset               (reset),
        .start_from_previous (start_from_previous),
        .fc_data_in          (fc_data_in),
        .end_to_previous     (end_to_previous),
        .busy                (busy),
        .class_out           (class_out),
        .max_value_out       (max_value_out),
        .class_valid         (class_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NC*DW-1:0] pack_vals();
        logic [NC*DW-1:0] p;
        p = '0;
        for (int k = 0; k < NC; k++) p[k*DW +: DW] = vals[k];
        return p;
    endfunction

    // Present vals with a start pulse; the capture edge is consumed here.
    task automatic send_vec();
        fc_data_in          = pack_vals();
        start_from_previous = 1'b1;
        tick();
        start_from_previous = 1'b0;
    endtask

    // Count edges after capture until class_valid, with a bounded wait.
    // Also checks the busy/ready handshake on every sampled cycle.
    task automatic wait_result(input string tag, input int exp_cls, input int exp_val);
        int  edges;
        bit  seen;
        edges = 0;
        seen  = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_ready"}, 32'(end_to_previous), 32'd0);
            tick();
            edges++;
            if (class_valid) seen = 1'b1;
        end
        check({tag, "_valid_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(edges), 32'(LATENCY));
        check({tag, "_class"}, 32'(class_out), 32'(exp_cls));
        check({tag, "_value"}, max_value_out, 32'(exp_val));
        check({tag, "_busy_done"}, 32'(busy), 32'd1);
        tick();
        check({tag, "_valid_drop"}, 32'(class_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(end_to_previous), 32'd1);
        check({tag, "_class_hold"}, 32'(class_out), 32'(exp_cls));
        check({tag, "_value_hold"}, max_value_out, 32'(exp_val));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        start_from_previous = 1'b0;
        fc_data_in = '0;
        tick();
        tick();
        check("rst_ready", 32'(end_to_previous), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_class", 32'(class_out), 32'd0);
        check("rst_value", max_value_out, 32'd0);
        check("rst_valid", 32'(class_valid), 32'd0);
        reset = 1'b0;
        tick();

        // Tie between classes 2 and 6 -> lower index wins.
        vals = '{3, -1, 7, 2, 0, 5, 7, -4, 1, 6};
        send_vec();
        wait_result("tie", 2, 7);

        // All negative, max -9 at class 1.
        vals = '{-50, -9, -30, -20, -70, -60, -10, -80, -90, -100};
        send_vec();
        wait_result("neg", 1, -9);

        // Maximum in the last class.
        vals = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h7FFFFFFF};
        send_vec();
        wait_result("last", 9, 32'h7FFFFFFF);

        // All most-negative: nothing is strictly greater than class 0.
        vals = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
                 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
        send_vec();
        wait_result("minval", 0, 32'h80000000);

        // Most-negative in class 0, small negative later must win.
        vals = '{32'h80000000, -2, -1, -3, -5, -8, -13, -21, -34, -55};
        send_vec();
        wait_result("minfirst", 2, -1);

        // Second start pulse mid-scan is ignored.
        begin
            int  edges;
            bit  seen;
            vals = '{-50, -9, -30, -20, -70, -60, -10, -80, -90, -100};
            send_vec();
            edges = 0;
            seen  = 1'b0;
            for (int c = 0; c < 30 && !seen; c++) begin
                check("midstart_busy", 32'(busy), 32'd1);
                check("midstart_ready", 32'(end_to_previous), 32'd0);
                if (c == 3) begin
                    vals = '{0, 0, 0, 0, 0, 100, 0, 0, 0, 0};
                    fc_data_in          = pack_vals();
                    start_from_previous = 1'b1;
                end
                tick();
                start_from_previous = 1'b0;
                edges++;
                if (class_valid) seen = 1'b1;
            end
            check("midstart_valid_seen", 32'(seen), 32'd1);
            check("midstart_latency", 32'(edges), 32'(LATENCY));
            check("midstart_class", 32'(class_out), 32'd1);
            check("midstart_value", max_value_out, 32'(-9));
            tick();
            check("midstart_no_restart", 32'(end_to_previous), 32'd1);
            check("midstart_valid_drop", 32'(class_valid), 32'd0);
        end

        // Reset at scan index 4 aborts the vector.
        begin
            bit seen;
            vals = '{3, -1, 7, 2, 0, 5, 7, -4, 1, 6};
            send_vec();
            tick();
            tick();
            tick();
            reset = 1'b1;
            #1;
            check("abort_class", 32'(class_out), 32'd0);
            check("abort_value", max_value_out, 32'd0);
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_ready", 32'(end_to_previous), 32'd1);
            check("abort_valid", 32'(class_valid), 32'd0);
            tick();
            reset = 1'b0;
            seen = 1'b0;
            for (int c = 0; c < 12; c++) begin
                tick();
                if (class_valid) seen = 1'b1;
            end
            check("abort_no_valid", 32'(seen), 32'd0);
            check("abort_idle", 32'(end_to_previous), 32'd1);
            vals = '{4, 8, 15, 16, 23, 42, 0, -7, 41, 1};
            send_vec();
            wait_result("post_abort", 5, 42);
        end

        // Input changes right after capture must not affect the result.
        vals = '{0, 0, 0, 50, 0, 0, 0, 0, 0, 0};
        send_vec();
        vals = '{0, 0, 0, 0, 0, 0, 0, 0, 99, 0};
        fc_data_in = pack_vals();
        wait_result("hold_in", 3, 50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
